// File: rtl/latch_strobe_gen.sv
// Front end for the lab D-latch: synchronises and debounces a push-button and a switch bus,
// then emits one enable strobe with a captured data word per accepted press.
module latch_strobe_gen #(
  parameter int DBNC_CYCLES = 16,
  parameter int DW          = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  input  logic [DW-1:0]    d_raw,
  output logic             e_out,
  output logic [DW-1:0]    d_out,
  output logic             btn_level,
  output logic [CNT_W-1:0] press_cnt,
  output logic [1:0]       dbgState
);

  localparam int DBW = $clog2(DBNC_CYCLES);
  localparam logic [DBW-1:0] CNT_LAST = DBW'(DBNC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } stateT;

  stateT          state;
  stateT          stateNext;
  logic [DBW-1:0] dbncCnt;
  logic [DBW-1:0] dbncNext;
  logic           strobeNext;

  logic           btnMeta;
  logic           btnS;
  logic [DW-1:0]  dMeta;
  logic [DW-1:0]  dS;

  // Two-flop synchronisers; nothing downstream looks at the raw pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnMeta <= 1'b0;
      btnS    <= 1'b0;
      dMeta   <= '0;
      dS      <= '0;
    end else begin
      btnMeta <= btn_raw;
      btnS    <= btnMeta;
      dMeta   <= d_raw;
      dS      <= dMeta;
    end
  end

  always_comb begin
    stateNext  = state;
    dbncNext   = dbncCnt;
    strobeNext = 1'b0;
    case (state)
      IDLE: begin
        if (btnS) stateNext = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btnS) begin
          stateNext = IDLE;
        end else if (dbncCnt == CNT_LAST) begin
          stateNext  = PRESSED;
          strobeNext = 1'b1;
        end else begin
          dbncNext = dbncCnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btnS) stateNext = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (btnS) begin
          stateNext = PRESSED;
        end else if (dbncCnt == CNT_LAST) begin
          stateNext = IDLE;
        end else begin
          dbncNext = dbncCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    // Every stability window starts counting from zero.
    if (stateNext != state) dbncNext = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dbncCnt   <= '0;
      e_out     <= 1'b0;
      d_out     <= '0;
      btn_level <= 1'b0;
      press_cnt <= '0;
    end else begin
      state     <= stateNext;
      dbncCnt   <= dbncNext;
      e_out     <= strobeNext;
      btn_level <= (stateNext == PRESSED) || (stateNext == RELEASE_WAIT);
      // d_out only moves together with the strobe so the latch never sees switch churn.
      if (strobeNext) begin
        d_out     <= dS;
        press_cnt <= press_cnt + 1'b1;
      end
    end
  end

  assign dbgState = state;

endmodule
